// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and the data memory.
// Stores are queued in a small FIFO. Queued stores drain to the memory write
// port on cycles when no load needs that port. Loads go straight to memory,
// and the youngest matching queued store is forwarded to the load.
module store_buffer #(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DIR_WIDTH = 8,
  parameter int DEPTH          = 4   // power of two, 2 or more
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic [DATA_DIR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0]     WriteData,
  output logic [DATA_WIDTH-1:0]     ReadData,
  output logic                      Stall,
  output logic                      MemWriteOut,
  output logic                      MemReadOut,
  output logic [DATA_DIR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0]     MemWriteData,
  input  logic [DATA_WIDTH-1:0]     MemReadData,
  output logic [$clog2(DEPTH):0]    Count,
  output logic                      Full,
  output logic                      Empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_DIR_WIDTH-1:0] entryAddr [DEPTH];
  logic [DATA_WIDTH-1:0]     entryData [DEPTH];
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;

  logic                      drain;
  logic                      accept;
  logic                      fwdHit;
  logic [DATA_WIDTH-1:0]     fwdData;

  // Port arbitration: a load owns the memory port, otherwise the head drains.
  // Stall depends only on MemWrite, MemRead and Count, never on MemReadData.
  always_comb begin
    Full         = (Count == DEPTH_C);
    Empty        = (Count == '0);
    drain        = !Empty && !MemRead;
    accept       = MemWrite && (!Full || drain);
    Stall        = MemWrite && Full && !drain;
    MemWriteOut  = drain;
    MemReadOut   = MemRead;
    MemAddress   = MemRead ? Address : entryAddr[head];
    MemWriteData = entryData[head];
  end

  // Forwarding search from oldest to youngest. A later match overwrites an
  // earlier one, so the youngest matching entry wins. A store arriving this
  // same cycle is not yet in the array, so this cycle's load cannot see it.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < Count) &&
          (entryAddr[head + PTR_W'(k)] == Address)) begin
        fwdHit  = 1'b1;
        fwdData = entryData[head + PTR_W'(k)];
      end
    end
    ReadData = '0;
    if (MemRead) begin
      ReadData = fwdHit ? fwdData : MemReadData;
    end
  end

  // FIFO state: enqueue at the tail on accept and pop the head on drain.
  // Reset discards every pending store and clears the entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      Count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryAddr[i] <= '0;
        entryData[i] <= '0;
      end
    end else begin
      if (accept) begin
        entryAddr[tail] <= Address;
        entryData[tail] <= WriteData;
        tail            <= tail + PTR_W'(1);
      end
      if (drain) begin
        head <= head + PTR_W'(1);
      end
      Count <= Count + CNT_W'(accept) - CNT_W'(drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer. A queue-based model holds the pending
// stores in program order. Expected outputs are derived from that queue and
// the arbitration rules, and the DUT is compared against them every cycle.
module tb_store_buffer;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          MemWrite;
  logic          MemRead;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;
  logic          Stall;
  logic          MemWriteOut;
  logic          MemReadOut;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemWriteData;
  logic [DW-1:0] MemReadData;
  logic [2:0]    Count;
  logic          Full;
  logic          Empty;

  store_buffer #(.DATA_WIDTH(DW), .DATA_DIR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .MemWriteOut(MemWriteOut), .MemReadOut(MemReadOut),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemReadData(MemReadData), .Count(Count), .Full(Full), .Empty(Empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] obsQ[$];
  bit            logOn = 1'b0;
  int            checks = 0;
  int            failures = 0;

  // One clock cycle. It is called at posedge+1: inputs are driven, outputs
  // are checked mid-cycle, and the model is advanced at the edge.
  task automatic cycle(input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] mrd);
    logic          expDrain;
    logic          expAcc;
    logic          expStall;
    logic          hit;
    logic [DW-1:0] expRd;
    ent_t          e;
    MemWrite    = w;
    MemRead     = r;
    Address     = a;
    WriteData   = wd;
    MemReadData = mrd;
    #2;
    expDrain = (q.size() != 0) && !r;
    expStall = w && (q.size() == DEPTH) && !expDrain;
    expAcc   = w && !expStall;
    expRd    = '0;
    if (r) begin
      expRd = mrd;
      hit   = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!hit && q[i].a == a) begin
          expRd = q[i].d;
          hit   = 1'b1;
        end
      end
    end
    checks++;
    if (Count !== 3'(q.size())) begin
      failures++;
      $display("FAIL count: got %0d expected %0d", Count, q.size());
    end
    checks++;
    if (Full !== (q.size() == DEPTH)) begin
      failures++;
      $display("FAIL full: got %b expected %b", Full, q.size() == DEPTH);
    end
    checks++;
    if (Empty !== (q.size() == 0)) begin
      failures++;
      $display("FAIL empty: got %b expected %b", Empty, q.size() == 0);
    end
    checks++;
    if (Stall !== expStall) begin
      failures++;
      $display("FAIL stall: got %b expected %b", Stall, expStall);
    end
    checks++;
    if (MemWriteOut !== expDrain) begin
      failures++;
      $display("FAIL memwriteout: got %b expected %b", MemWriteOut, expDrain);
    end
    checks++;
    if (MemReadOut !== r) begin
      failures++;
      $display("FAIL memreadout: got %b expected %b", MemReadOut, r);
    end
    checks++;
    if (ReadData !== expRd) begin
      failures++;
      $display("FAIL readdata addr=%h: got %h expected %h", a, ReadData, expRd);
    end
    if (r) begin
      checks++;
      if (MemAddress !== a) begin
        failures++;
        $display("FAIL memaddress_load: got %h expected %h", MemAddress, a);
      end
    end
    if (expDrain) begin
      checks++;
      if (MemAddress !== q[0].a || MemWriteData !== q[0].d) begin
        failures++;
        $display("FAIL drain_head: got %h/%h expected %h/%h",
                 MemAddress, MemWriteData, q[0].a, q[0].d);
      end
    end
    if (logOn && MemWriteOut) obsQ.push_back(MemAddress);
    @(posedge clk);
    if (expDrain) void'(q.pop_front());
    if (expAcc) begin
      e.a = a;
      e.d = wd;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic drain_all();
    for (int n = 0; n < 3 * DEPTH && q.size() != 0; n++) cycle(0, 0, '0, '0, '0);
  endtask

  task automatic test_reset();
    // Power-on reset: state is cleared and the outputs are quiet.
    rst = 1'b0; MemWrite = 1'b1; MemRead = 1'b0; Address = 8'h33;
    WriteData = 8'h44; MemReadData = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (Count !== 3'd0 || Empty !== 1'b1 || Full !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got count=%0d empty=%b full=%b expected 0/1/0", Count, Empty, Full);
    end
    checks++;
    if (MemWriteOut !== 1'b0 || Stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got mwo=%b stall=%b expected 0/0", MemWriteOut, Stall);
    end
    checks++;
    if (MemAddress !== 8'h00 || ReadData !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr_rd: got %h/%h expected 00/00", MemAddress, ReadData);
    end
    rst = 1'b1;
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
    // Mid-sequence reset with three entries held behind a load.
    cycle(1, 1, 8'h41, 8'h11, 8'h00);
    cycle(1, 1, 8'h42, 8'h22, 8'h00);
    cycle(1, 1, 8'h43, 8'h33, 8'h00);
    MemWrite = 1'b0; MemRead = 1'b0;
    #1;
    checks++;
    if (MemWriteOut !== 1'b1 || Count !== 3'd3) begin
      failures++;
      $display("FAIL pre_reset: got mwo=%b count=%0d expected 1/3", MemWriteOut, Count);
    end
    rst = 1'b0;
    MemWrite = 1'b1;
    #1;
    checks++;
    if (Count !== 3'd0 || Empty !== 1'b1 || MemWriteOut !== 1'b0 || Stall !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got count=%0d empty=%b mwo=%b stall=%b expected 0/1/0/0",
               Count, Empty, MemWriteOut, Stall);
    end
    q.delete();
    #1;
    rst = 1'b1;
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 0, '0, '0, '0);
    cycle(0, 1, 8'h41, '0, 8'hC1);
    cycle(0, 1, 8'h43, '0, 8'hC3);
  endtask

  task automatic test_single_store();
    drain_all();
    cycle(1, 0, 8'h02, 8'h55, '0);
    cycle(0, 0, '0, '0, '0);
    cycle(0, 0, '0, '0, '0);
  endtask

  task automatic test_forwarding();
    drain_all();
    cycle(1, 1, 8'h01, 8'hAA, 8'h00);
    cycle(1, 1, 8'h01, 8'hBB, 8'h00);
    cycle(0, 1, 8'h01, 8'h00, 8'h5A);
    cycle(0, 1, 8'h03, 8'h00, 8'h3C);
    drain_all();
  endtask

  task automatic test_full_stall();
    drain_all();
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 8'(8'h20 + i), 8'(8'hA0 + i), 8'h00);
    cycle(1, 1, 8'h28, 8'hEE, 8'h00);
    cycle(1, 0, 8'h30, 8'hF0, 8'h00);
    drain_all();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] expA;
    drain_all();
    obsQ.delete();
    logOn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) cycle(0, 1, 8'h99, 8'h00, 8'h00);
      cycle(1, 0, 8'(8'h10 + i), 8'(8'h60 + i), 8'h00);
    end
    drain_all();
    logOn = 1'b0;
    checks++;
    if (obsQ.size() != 6) begin
      failures++;
      $display("FAIL wrap_count: got %0d writes expected 6", obsQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < 6; i++) begin
      expA = 8'(8'h10 + i);
      checks++;
      if (obsQ[i] !== expA) begin
        failures++;
        $display("FAIL wrap_order[%0d]: got %h expected %h", i, obsQ[i], expA);
      end
    end
  endtask

  task automatic test_same_cycle();
    drain_all();
    cycle(1, 1, 8'h07, 8'h99, 8'h12);
    cycle(0, 1, 8'h07, 8'h00, 8'h34);
    drain_all();
  endtask

  task automatic test_random();
    logic w;
    logic r;
    for (int n = 0; n < 400; n++) begin
      w = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      cycle(w, r, 8'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end
    drain_all();
  endtask

  initial begin
    rst = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    Address = '0; WriteData = '0; MemReadData = '0;
    test_reset();
    test_single_store();
    test_forwarding();
    test_full_stall();
    test_wrap();
    test_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the EX/MEM pipeline register and the data memory. Stores from the pipeline are queued in a small FIFO and drained into the memory's write port on cycles when no load needs the port. Loads go straight to the memory, with store-to-load forwarding from the youngest matching queued entry. The buffer stalls the pipeline only when it is full and cannot drain.

## Interface
- DATA_WIDTH, 8, data word width.
- DATA_DIR_WIDTH, 8, address width.
- DEPTH, 4, number of entries. Must be a power of two, 2 or more.
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- MemWrite  input  1  store request from EX/MEM.
- MemRead  input  1  load request from EX/MEM.
- Address  input  DATA_DIR_WIDTH  load/store address.
- WriteData  input  DATA_WIDTH  store data.
- ReadData  output  DATA_WIDTH  load result to MEM/WB. Forwarded or memory data when MemRead=1, else 0.
- Stall  output  1  store not accepted this cycle; pipeline must hold.
- MemWriteOut  output  1  write enable to data memory.
- MemReadOut  output  1  read enable to data memory (equals MemRead).
- MemAddress  output  DATA_DIR_WIDTH  address to data memory.
- MemWriteData  output  DATA_WIDTH  write data to data memory (head entry).
- MemReadData  input  DATA_WIDTH  combinational read data from data memory.
- Count  output  $clog2(DEPTH)+1  occupied entries.
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.

## Operation
- Storage: DEPTH entries of {addr, data}, head and tail pointers of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH. Count is a separate register.
- drain = !Empty && !MemRead. Loads always take priority for the memory port.
- When drain=1: MemWriteOut=1, MemAddress=head.addr, MemWriteData=head.data. The head pops at the next edge.
- When MemRead=1: MemWriteOut=0, MemAddress=Address. MemWriteData still shows the head entry (don't-care).
- When idle (no read, no drain): MemWriteOut=0, MemAddress=head.addr.
- Store acceptance: accept = MemWrite && (!Full || drain). On accept, {Address, WriteData} is written at the tail and tail increments.
- Stall = MemWrite && Full && !drain, evaluated combinationally.
- Count update:
  - Next Count = Count + accept − drain.
  - Full with drain and accept in the same cycle: Count stays DEPTH, with no stall.
- Forwarding: on MemRead=1, compare the full Address against every valid entry.
  - ReadData = data of the youngest matching entry (closest to tail) if any match, else MemReadData.
- Same-cycle MemRead and MemWrite: the store is enqueued if not stalled, but it is not visible to that cycle's load.
- Reset (rst=0, asynchronous):
  - Count=0, head=tail=0, all entries cleared to 0.
  - Outputs: MemWriteOut=0, Stall=0, Empty=1, Full=0, MemAddress=0 unless MemRead, ReadData=0 unless MemRead.
  - Pending stores are discarded.
- No other state machine: the only state is the FIFO, with Empty/Partial/Full derived from Count.

## Timing
- Store accepted at edge N is forwardable to loads from cycle N+1.
- That store can drain from cycle N+1 at the earliest.
- Minimum store-to-memory latency: 1 cycle, empty buffer and no load.
- Drain throughput: 1 entry per cycle without loads. Drain order is strict FIFO.
- Load latency: 0 cycles, combinational through forwarding mux or MemReadData.
- Stall, MemWriteOut, MemAddress and ReadData are combinational from inputs and registered state. There is no combinational path from MemReadData to Stall.
- Reset assertion forces MemWriteOut=0 immediately, without waiting for clk.

## Test plan
- Reset with rst=0 mid-sequence holding 3 entries → immediately Count=0, Empty=1, MemWriteOut=0, Stall=0. Entries remain absent after release.
- Single store at Address=0x02, WriteData=0x55, empty buffer, MemRead=0:
  - Next cycle: MemWriteOut=1, MemAddress=0x02, MemWriteData=0x55.
  - Following edge: Empty=1.
- Forwarding with MemRead held 1:
  - Stores 0x01→0xAA, then 0x01→0xBB.
  - Load 0x01 → ReadData=0xBB.
  - Load 0x03 with MemReadData=0x3C → ReadData=0x3C.
- Full/stall with MemRead held 1:
  - 4 stores → Full=1.
  - 5th store → Stall=1, Count stays 4.
  - Then MemRead=0 with a store present → Stall=0, Count=4, head drained.
- Wrap-around: 6 stores to addresses 0x10..0x15 interleaved with drains → memory sees writes in exact order 0x10..0x15. Pointers wrap with no loss or duplication.
- Same-cycle load and store to 0x07 with no older entry → ReadData=MemReadData. The next-cycle load of 0x07 returns the new store data.
